mode_counter: RTL
=================

// Module: mode_counter
// PURPOSE
//  Parametrised successor to the basic enable counter. It counts up or down over 0..modulus,
//  wraps or saturates at the terminal value, and steps through a programmable prescaler.
//  It has synchronous clear/load, a one-cycle terminal-count pulse and a sticky overflow flag.
//  Serves as the shared timebase/event counter for the FPGA bus-test blocks (bit timers, timeouts).
// PARAMETERS
//  WIDTH       8   counter width; count, load_val, modulus are WIDTH bits
//  PRESC_W     4   prescaler width; step every (presc+1) enabled cycles
// PORTS
//  clk       in   1        clock, all state on rising edge
//  rst       in   1        reset, asynchronous, active-high
//  en        in   1        count enable (gates prescaler)
//  clr       in   1        synchronous clear
//  load      in   1        synchronous load of load_val
//  load_val  in   WIDTH    value for load
//  dir       in   1        1 = up, 0 = down
//  sat       in   1        1 = saturate at terminal, 0 = wrap
//  modulus   in   WIDTH    upper bound of count range (inclusive)
//  presc     in   PRESC_W  prescale divisor minus one (0 = step every enabled cycle)
//  count     out  WIDTH    current count
//  tc        out  1        terminal-count pulse, one cycle
//  ovf       out  1        sticky overflow/underflow flag
// BEHAVIOUR
//  - Reset (rst high, async): count=0, prescaler=0, tc=0, ovf=0; rst dominates everything.
//  - Priority per edge: clr > load > step. Both clr and load high -> clr wins.
//  - clr: count=0, prescaler=0, tc=0, ovf=0.
//  - load: count = (load_val > modulus) ? modulus : load_val; prescaler=0; tc=0; ovf held.
//  - Prescaler: en low -> holds. en high and pcnt >= presc -> pcnt=0 and a step occurs.
//    Otherwise pcnt++. Using >= means a mid-count decrease of presc does not run away.
//  - Step, dir=1: terminal when count >= modulus; non-terminal -> count+1.
//    Terminal -> count=0 (sat=0) or count=modulus (sat=1).
//  - Step, dir=0: terminal when count == 0; non-terminal -> count-1.
//    Terminal -> count=modulus (sat=0) or stays 0 (sat=1).
//  - tc: registered; high for exactly the one cycle after a terminal step, else 0.
//    In sat mode tc pulses on every step taken while held at terminal.
//  - ovf: set with tc, held until clr or rst.
//  - Latency: count, tc, ovf all update on the edge that samples the step; no pipeline.
//  - modulus=0: count stays 0; every step is terminal -> tc on every step.
//  - modulus lowered below count while counting up: next step is terminal (wrap to 0 / clamp).
//  - dir, sat, modulus may change any cycle; they take effect on the next step.
//  - All arithmetic is WIDTH bits unsigned; no intermediate overflow, as terminal is checked first.
// CONFIGURATION
//  COUNTER_CAPTURE_EN defined: adds ports cap (in,1) and cap_val (out,WIDTH).
//    cap_val <= count (pre-update value) on an edge with cap high; reset 0; clr clears it.
//    The capture does not disturb counting.
//  Not defined: cap/cap_val ports and capture register are absent; the rest is identical.
// TESTING
//  1. WIDTH=8, modulus=5, presc=0, dir=1, sat=0, en=1 from 0 -> count 0..5,0; tc one cycle after 5->0; ovf=1 stays.
//  2. presc=3, modulus=255, en=1 for 12 cycles -> count=3.
//     en low for 5 cycles mid-way -> count frozen, prescaler phase held.
//  3. dir=0, sat=1, load_val=2 -> count 2,1,0,0,0; tc pulses on each step at 0.
//     Then clr -> count=0, ovf=0, tc=0.
//  4. load_val=200, modulus=100, load=1 -> count=100.
//     Same cycle clr=1 and load=1 -> count=0.
//  5. rst asserted asynchronously mid-count (count=37, presc=2 phase 1) -> count, tc, ovf =0 immediately.
//     First step 3 enabled cycles after rst release.
//  6. With COUNTER_CAPTURE_EN: cap pulse at count=42 while counting -> cap_val=42.
//     Counting continues 43,44 uninterrupted.

Source files
------------

// File: rtl/mode_counter.sv
// Up/down modulus counter with prescaler, wrap/saturate, terminal-count pulse and sticky overflow.
// Optional capture register (cap/cap_val) enabled by defining COUNTER_CAPTURE_EN.
module mode_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               dir,
  input  logic               sat,
  input  logic [WIDTH-1:0]   modulus,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               ovf
`ifdef COUNTER_CAPTURE_EN
  ,
  input  logic               cap,
  output logic [WIDTH-1:0]   cap_val
`endif
);

  logic [WIDTH-1:0]   r_count;
  logic [PRESC_W-1:0] r_pcnt;
  logic               r_tc;
  logic               r_ovf;

  logic               w_step;
  logic               w_terminal;
  logic [WIDTH-1:0]   w_count_step;
  logic [WIDTH-1:0]   w_load_clamped;
  logic [PRESC_W-1:0] w_pcnt_next;

  // Terminal is decided before any +1/-1, so the arithmetic never overflows.
  always_comb begin
    w_step         = en && (r_pcnt >= presc);
    w_pcnt_next    = r_pcnt;
    w_terminal     = 1'b0;
    w_count_step   = r_count;
    w_load_clamped = (load_val > modulus) ? modulus : load_val;
    if (en) begin
      w_pcnt_next = w_step ? '0 : r_pcnt + 1'b1;
    end
    if (dir) begin
      w_terminal   = (r_count >= modulus);
      w_count_step = w_terminal ? (sat ? modulus : '0) : r_count + 1'b1;
    end else begin
      w_terminal   = (r_count == '0);
      w_count_step = w_terminal ? (sat ? '0 : modulus) : r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_pcnt  <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_pcnt  <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_pcnt  <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_pcnt <= w_pcnt_next;
      r_tc   <= w_step && w_terminal;
      if (w_step) begin
        r_count <= w_count_step;
        if (w_terminal) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] r_cap_val;

  // Captures the pre-update count; independent of the counting path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_val <= '0;
    end else if (clr) begin
      r_cap_val <= '0;
    end else if (cap) begin
      r_cap_val <= r_count;
    end
  end

  assign cap_val = r_cap_val;
`endif

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule
